// File: rtl/vm_change_dispenser_pkg.sv
// Shared vending-machine definitions: coin denominations, widths and the
// change-dispenser FSM encoding.
package vm_change_dispenser_pkg;

  localparam int unsigned kNumCoins  = 3;
  localparam int unsigned kWaitTimeW = 32;
  localparam int unsigned kBalW      = 31;

  localparam int unsigned kCoinVal0 = 100;
  localparam int unsigned kCoinVal1 = 500;
  localparam int unsigned kCoinVal2 = 1000;

  typedef enum logic [1:0] {
    StIdle,
    StSelect,
    StDispense,
    StDone
  } state_e;

  function automatic int unsigned coin_val(input int unsigned idx);
    case (idx)
      0:       return kCoinVal0;
      1:       return kCoinVal1;
      2:       return kCoinVal2;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/vm_change_dispenser_if.sv
// Coin-hopper handshake: the dispenser presents one-hot coins, the hopper
// acknowledges with ready and reports which coin tubes are empty.
interface vm_change_dispenser_if;

  logic                                          return_valid;
  logic [vm_change_dispenser_pkg::kNumCoins-1:0] return_coin;
  logic                                          hopper_ready;
  logic [vm_change_dispenser_pkg::kNumCoins-1:0] coin_empty;

  modport master (
    output return_valid,
    output return_coin,
    input  hopper_ready,
    input  coin_empty
  );

  modport slave (
    input  return_valid,
    input  return_coin,
    output hopper_ready,
    output coin_empty
  );

endinterface

// File: rtl/vm_change_dispenser_coin_pick.sv
// Combinational coin chooser: largest in-stock coin that still fits in the
// remaining balance.
module vm_coin_pick
  import vm_change_dispenser_pkg::*;
#(
  parameter int unsigned BAL_W = kBalW
) (
  input  logic [BAL_W-1:0]     rem,
  input  logic [kNumCoins-1:0] coin_empty,
  output logic                 pick_valid,
  output logic [kNumCoins-1:0] pick_onehot,
  output logic [BAL_W-1:0]     pick_val
);

  // Ascending scan so the highest qualifying index overwrites smaller ones.
  always_comb begin
    pick_valid  = 1'b0;
    pick_onehot = '0;
    pick_val    = '0;
    for (int unsigned i = 0; i < kNumCoins; i++) begin
      if (!coin_empty[i] && (BAL_W'(coin_val(i)) <= rem)) begin
        pick_valid     = 1'b1;
        pick_onehot    = '0;
        pick_onehot[i] = 1'b1;
        pick_val       = BAL_W'(coin_val(i));
      end
    end
  end

endmodule

// File: rtl/vm_change_dispenser.sv
// Returns the latched balance as coins to the hopper once the wait timer
// expires, reporting the total returned and any unreturnable residual.
module vm_change_dispenser
  import vm_change_dispenser_pkg::*;
#(
  parameter int unsigned BAL_W = kBalW
) (
  input  logic                   clk,
  input  logic                   reset_n,
  vm_change_dispenser_if.master  hop,
  input  logic [kWaitTimeW-1:0]  i_wait_time,
  input  logic [BAL_W-1:0]       i_balance,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_clear_balance,
  output logic [BAL_W-1:0]       o_returned,
  output logic [BAL_W-1:0]       o_residual
);

  state_e                state_q;
  logic [kWaitTimeW-1:0] prev_wait_q;
  logic [BAL_W-1:0]      rem_q;
  logic [BAL_W-1:0]      val_q;
  logic                  valid_q;
  logic [kNumCoins-1:0]  coin_q;

  logic                  expiry;
  logic                  pick_valid;
  logic [kNumCoins-1:0]  pick_onehot;
  logic [BAL_W-1:0]      pick_val;

  assign expiry           = (i_wait_time == '0) && (prev_wait_q != '0);
  assign o_busy           = (state_q != StIdle);
  assign hop.return_valid = valid_q;
  assign hop.return_coin  = coin_q;

  vm_coin_pick #(
    .BAL_W (BAL_W)
  ) u_coin_pick (
    .rem         (rem_q),
    .coin_empty  (hop.coin_empty),
    .pick_valid  (pick_valid),
    .pick_onehot (pick_onehot),
    .pick_val    (pick_val)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= StIdle;
      prev_wait_q     <= '0;
      rem_q           <= '0;
      val_q           <= '0;
      valid_q         <= 1'b0;
      coin_q          <= '0;
      o_done          <= 1'b0;
      o_clear_balance <= 1'b0;
      o_returned      <= '0;
      o_residual      <= '0;
    end else begin
      prev_wait_q     <= i_wait_time;
      o_done          <= 1'b0;
      o_clear_balance <= 1'b0;
      case (state_q)
        StIdle: begin
          if (expiry && (i_balance != '0)) begin
            rem_q      <= i_balance;
            o_returned <= '0;
            o_residual <= '0;
            state_q    <= StSelect;
          end
        end
        StSelect: begin
          if (pick_valid) begin
            coin_q  <= pick_onehot;
            val_q   <= pick_val;
            valid_q <= 1'b1;
            state_q <= StDispense;
          end else begin
            // Pulses are raised here so they are visible during the DONE cycle.
            o_done          <= 1'b1;
            o_clear_balance <= 1'b1;
            state_q         <= StDone;
          end
        end
        StDispense: begin
          if (hop.hopper_ready) begin
            rem_q      <= rem_q - val_q;
            o_returned <= o_returned + val_q;
            valid_q    <= 1'b0;
            coin_q     <= '0;
            state_q    <= StSelect;
          end
        end
        StDone: begin
          o_residual <= rem_q;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_vm_change_dispenser.sv
// Directed bench for vm_change_dispenser: vector table of full return
// sequences plus hand-written stall, reset-abort and no-start cases.
module tb_vm_change_dispenser;

  logic        clk;
  logic        reset_n;
  logic [31:0] wait_time;
  logic [30:0] balance;
  logic        busy;
  logic        done;
  logic        clear_balance;
  logic [30:0] returned;
  logic [30:0] residual;

  int n_cmp  = 0;
  int n_fail = 0;

  vm_change_dispenser_if hop_if ();

  vm_change_dispenser dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .hop             (hop_if.master),
    .i_wait_time     (wait_time),
    .i_balance       (balance),
    .o_busy          (busy),
    .o_done          (done),
    .o_clear_balance (clear_balance),
    .o_returned      (returned),
    .o_residual      (residual)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // coins: slot k (issue order) at [3k+:3]
  typedef struct packed {
    logic [30:0] bal;
    logic [2:0]  empty;
    logic [2:0]  n;
    logic [11:0] coins;
    logic [30:0] ret;
    logic [30:0] res;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic start_expiry(input logic [30:0] bal);
    @(negedge clk);
    balance   = bal;
    wait_time = 32'd1;
    @(negedge clk);
    wait_time = 32'd0;
  endtask

  task automatic do_vector(input vec_t v);
    logic [2:0] got[8];
    int         seen = 0;
    bit         fin  = 1'b0;
    hop_if.coin_empty   = v.empty;
    hop_if.hopper_ready = 1'b1;
    start_expiry(v.bal);
    for (int c = 0; c < 60 && !fin; c++) begin
      @(negedge clk);
      if (c == 0) balance = '1;  // must be ignored while busy
      chk("clear_eq_done", 32'(clear_balance), 32'(done));
      if (hop_if.return_valid) begin
        if (seen < 8) got[seen] = hop_if.return_coin;
        seen++;
      end
      if (done) begin
        fin = 1'b1;
        chk("returned_at_done", 32'(returned), 32'(v.ret));
      end
    end
    if (!fin) chk("done_timeout", 32'd0, 32'd1);
    chk("coin_count", 32'(seen), 32'(v.n));
    for (int k = 0; k < 4; k++) begin
      if (k < int'(v.n) && k < seen) chk("coin", 32'(got[k]), 32'(v.coins[3*k +: 3]));
    end
    @(negedge clk);
    chk("busy_after", 32'(busy), 32'd0);
    chk("done_single", 32'(done), 32'd0);
    chk("residual", 32'(residual), 32'(v.res));
    chk("returned_held", 32'(returned), 32'(v.ret));
  endtask

  initial begin
    bit saw_busy;
    bit saw_done;

    vecs[0] = '{bal: 31'd1600, empty: 3'b000, n: 3'd3,
                coins: {3'b000, 3'b001, 3'b010, 3'b100}, ret: 31'd1600, res: 31'd0};
    vecs[1] = '{bal: 31'd1600, empty: 3'b100, n: 3'd4,
                coins: {3'b001, 3'b010, 3'b010, 3'b010}, ret: 31'd1600, res: 31'd0};
    vecs[2] = '{bal: 31'd250,  empty: 3'b000, n: 3'd2,
                coins: {3'b000, 3'b000, 3'b001, 3'b001}, ret: 31'd200,  res: 31'd50};
    vecs[3] = '{bal: 31'd1100, empty: 3'b001, n: 3'd1,
                coins: {3'b000, 3'b000, 3'b000, 3'b100}, ret: 31'd1000, res: 31'd100};
    vecs[4] = '{bal: 31'd50,   empty: 3'b000, n: 3'd0,
                coins: 12'd0, ret: 31'd0, res: 31'd50};
    vecs[5] = '{bal: 31'd1000, empty: 3'b000, n: 3'd1,
                coins: {3'b000, 3'b000, 3'b000, 3'b100}, ret: 31'd1000, res: 31'd0};

    reset_n             = 1'b0;
    wait_time           = 32'd0;
    balance             = 31'd700;
    hop_if.coin_empty   = 3'b000;
    hop_if.hopper_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(hop_if.return_valid), 32'd0);
    chk("rst_coin", 32'(hop_if.return_coin), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_clear", 32'(clear_balance), 32'd0);
    chk("rst_returned", 32'(returned), 32'd0);
    chk("rst_residual", 32'(residual), 32'd0);

    // wait_time held at 0 from reset: no falling edge, so no start
    reset_n  = 1'b1;
    saw_busy = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
    end
    chk("no_start_wait0", 32'(saw_busy), 32'd0);

    // expiry with zero balance: never busy, no done
    start_expiry(31'd0);
    saw_busy = 1'b0;
    saw_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
      if (done) saw_done = 1'b1;
    end
    chk("no_start_bal0_busy", 32'(saw_busy), 32'd0);
    chk("no_start_bal0_done", 32'(saw_done), 32'd0);

    for (int i = 0; i < 5; i++) do_vector(vecs[i]);

    // Hopper stalls 3 cycles: coin must stay presented and count once
    hop_if.coin_empty   = 3'b000;
    hop_if.hopper_ready = 1'b0;
    start_expiry(31'd500);
    @(negedge clk);
    chk("lat_busy_n1", 32'(busy), 32'd1);
    chk("lat_valid_n1", 32'(hop_if.return_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stall_valid", 32'(hop_if.return_valid), 32'd1);
      chk("stall_coin", 32'(hop_if.return_coin), 32'd2);
      chk("stall_returned", 32'(returned), 32'd0);
      if (k == 3) hop_if.hopper_ready = 1'b1;
    end
    @(negedge clk);
    chk("stall_valid_drop", 32'(hop_if.return_valid), 32'd0);
    chk("stall_returned_once", 32'(returned), 32'd500);
    @(negedge clk);
    chk("stall_done", 32'(done), 32'd1);
    chk("stall_clear", 32'(clear_balance), 32'd1);
    @(negedge clk);
    chk("stall_returned_final", 32'(returned), 32'd500);
    chk("stall_residual", 32'(residual), 32'd0);
    chk("stall_idle", 32'(busy), 32'd0);

    // Reset while a coin is presented: abort without done/clear
    hop_if.hopper_ready = 1'b0;
    start_expiry(31'd1000);
    saw_busy = 1'b0;
    for (int c = 0; c < 10 && !saw_busy; c++) begin
      @(negedge clk);
      if (hop_if.return_valid) saw_busy = 1'b1;
    end
    chk("abort_reached_dispense", 32'(saw_busy), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("abort_valid", 32'(hop_if.return_valid), 32'd0);
    chk("abort_coin", 32'(hop_if.return_coin), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_clear", 32'(clear_balance), 32'd0);
    reset_n  = 1'b1;
    saw_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    chk("abort_quiet", 32'(saw_done), 32'd0);
    do_vector(vecs[5]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
